// File: rtl/lcd_id_if.sv
// Panel-identification bus between the strap reader and the display path.
// Carries the raw strap pins, the reread request and the decoded panel ID.
interface lcd_id_if;
    logic [2:0]  strap_in;
    logic        reread;
    logic        lcd_rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_err;

    modport master (
        output strap_in, reread,
        input  lcd_rgb_oe, lcd_id, id_valid, id_err
    );

    modport slave (
        input  strap_in, reread,
        output lcd_rgb_oe, lcd_id, id_valid, id_err
    );
endinterface

// File: rtl/lcd_id_reader.sv
// Power-up RGB panel identification from the R7/G7/B7 strap resistors.
// Pins stay released until a stable code (or an error) is latched.
module lcd_id_reader #(
    parameter int SETTLE_CYC = 5000,
    parameter int SAMPLE_NUM = 4,
    parameter int SAMPLE_GAP = 50,
    parameter int MAX_RETRY  = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    lcd_id_if.slave  bus
);
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_GAP) ? SETTLE_CYC : SAMPLE_GAP;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = $clog2(SAMPLE_NUM + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(SAMPLE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(SAMPLE_NUM - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [2:0]    sync1;
    logic [2:0]    s_strap;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    ref_code;
    logic          oe_q;
    logic [15:0]   id_q;
    logic          valid_q;
    logic          err_q;

    logic          take;
    logic          match;
    logic [15:0]   dec_id;
    logic          dec_ok;

    // The first sample of an attempt is taken on entry; later ones every gap.
    always_comb begin
        take  = (idx == '0) || (cnt == GAP_LAST);
        match = (idx == '0) || (s_strap == ref_code);
    end

    always_comb begin
        dec_id = 16'h0000;
        dec_ok = 1'b0;
        case (s_strap)
            3'b000: begin dec_id = 16'h4342; dec_ok = 1'b1; end
            3'b001: begin dec_id = 16'h7084; dec_ok = 1'b1; end
            3'b010: begin dec_id = 16'h7016; dec_ok = 1'b1; end
            3'b100: begin dec_id = 16'h4384; dec_ok = 1'b1; end
            3'b101: begin dec_id = 16'h1018; dec_ok = 1'b1; end
            default: begin dec_id = 16'h0000; dec_ok = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            s_strap   <= '0;
            state     <= ST_SETTLE;
            cnt       <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            ref_code  <= '0;
            oe_q      <= 1'b0;
            id_q      <= 16'h0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1   <= bus.strap_in;
            s_strap <= sync1;
            case (state)
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (!take) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (idx == '0)
                            ref_code <= s_strap;
                        if (!match) begin
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= ST_SETTLE;
                            end else begin
                                state   <= ST_DONE;
                                id_q    <= 16'h0000;
                                err_q   <= 1'b1;
                                valid_q <= 1'b1;
                                oe_q    <= 1'b1;
                            end
                        end else if (idx == IDX_LAST) begin
                            // On a match s_strap equals ref_code.
                            state   <= ST_DONE;
                            id_q    <= dec_id;
                            err_q   <= !dec_ok;
                            valid_q <= 1'b1;
                            oe_q    <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.reread) begin
                        state     <= ST_SETTLE;
                        cnt       <= '0;
                        retry_cnt <= '0;
                        valid_q   <= 1'b0;
                        err_q     <= 1'b0;
                        oe_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_SETTLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.lcd_rgb_oe = oe_q;
    assign bus.lcd_id     = id_q;
    assign bus.id_valid   = valid_q;
    assign bus.id_err     = err_q;
endmodule

// File: tb/tb_lcd_id_reader.sv
// Randomized bench for lcd_id_reader against a strap-timeline reference model.
// hist[n] is the strap value driven before the n-th clock edge after reset release.
module tb_lcd_id_reader;
    localparam int S = 40;
    localparam int N = 4;
    localparam int G = 10;
    localparam int R = 3;
    localparam int HMAX = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_id_if bus ();

    lcd_id_reader #(
        .SETTLE_CYC(S),
        .SAMPLE_NUM(N),
        .SAMPLE_GAP(G),
        .MAX_RETRY (R)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad = 0;
    logic [2:0] hist [0:HMAX];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // {err, id} straight from the panel table.
    function automatic logic [16:0] dec(input logic [2:0] c);
        case (c)
            3'b000: return {1'b0, 16'h4342};
            3'b001: return {1'b0, 16'h7084};
            3'b010: return {1'b0, 16'h7016};
            3'b100: return {1'b0, 16'h4384};
            3'b101: return {1'b0, 16'h1018};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    // Value seen by the reader at edge e (two-flop synchronizer delay).
    function automatic logic [2:0] seen(input int e);
        if (e < 3) return 3'b000;
        if (e - 2 > HMAX) return hist[HMAX];
        return hist[e-2];
    endfunction

    // Attempt starts settling at edge b; returns result edge and {err,id}.
    function automatic void model(input int b, output int de,
                                  output logic [16:0] res);
        int start;
        int ebad;
        logic [2:0] rc;
        start = b;
        de = -1;
        res = '0;
        for (int a = 0; a <= R; a++) begin
            rc = seen(start + S);
            ebad = 0;
            for (int k = 1; k < N; k++)
                if (ebad == 0 && seen(start + S + k * G) != rc)
                    ebad = start + S + k * G;
            if (ebad == 0) begin
                de = start + S + (N - 1) * G;
                res = dec(rc);
                return;
            end
            if (a == R) begin
                de = ebad;
                res = {1'b1, 16'h0000};
                return;
            end
            start = ebad + 1;
        end
    endfunction

    task automatic fill(input logic [2:0] c);
        for (int i = 0; i <= HMAX; i++) hist[i] = c;
    endtask

    task automatic step();
        bus.strap_in = hist[(cyc + 1 > HMAX) ? HMAX : cyc + 1];
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic start_run();
        rst_n = 1'b0;
        bus.reread = 1'b0;
        bus.strap_in = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_done(output int de);
        bad = 0;
        de = -1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.lcd_rgb_oe !== bus.id_valid) bad++;
            if (bus.id_valid === 1'b1) begin
                de = cyc;
                break;
            end
        end
    endtask

    task automatic check_done(input string tag, input int de, input int me,
                              input logic [16:0] res);
        chk({tag, "_edge"}, de, me);
        chk({tag, "_id"}, {16'h0, bus.lcd_id}, {16'h0, res[15:0]});
        chk({tag, "_err"}, {31'h0, bus.id_err}, {31'h0, res[16]});
        chk({tag, "_oe"}, {31'h0, bus.lcd_rgb_oe}, 1);
        chk({tag, "_oe_track"}, bad, 0);
    endtask

    task automatic run_case(input string tag, input bit lat, output int de);
        int me;
        logic [16:0] res;
        start_run();
        wait_done(de);
        model(1, me, res);
        check_done(tag, de, me, res);
        if (lat) begin
            me = 2 + S + (N - 1) * G + 1;
            chk({tag, "_lat"}, {31'h0, (de >= me - 2 && de <= me + 2)}, 1);
        end
    endtask

    initial begin
        int de;
        int me;
        int r;
        int st;
        int len;
        logic [2:0] code;
        logic [16:0] res;

        bus.strap_in = 3'b000;
        bus.reread = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_oe", {31'h0, bus.lcd_rgb_oe}, 0);
        chk("rst_id", {16'h0, bus.lcd_id}, 0);
        chk("rst_valid", {31'h0, bus.id_valid}, 0);
        chk("rst_err", {31'h0, bus.id_err}, 0);

        fill(3'b001);
        run_case("s001", 1'b1, de);
        chk("s001_const", {16'h0, bus.lcd_id}, 32'h7084);

        for (int c = 0; c < 8; c++) begin
            fill(3'(c));
            run_case($sformatf("code%0d", c), 1'b1, de);
            chk($sformatf("code%0d_valid", c), {31'h0, bus.id_valid}, 1);
        end

        fill(3'b101);
        for (int n = S + G + 3; n <= S + G + 12; n++) hist[n] = 3'b100;
        run_case("glitch", 1'b0, de);
        chk("glitch_const", {16'h0, bus.lcd_id}, 32'h1018);
        chk("glitch_retry", {31'h0, (de > S + (N - 1) * G + 3)}, 1);

        for (int n = 0; n <= HMAX; n++)
            hist[n] = ((n / 30) % 2 == 1) ? 3'b010 : 3'b001;
        run_case("toggle", 1'b0, de);
        chk("toggle_err", {31'h0, bus.id_err}, 1);
        chk("toggle_id", {16'h0, bus.lcd_id}, 0);

        for (int t = 0; t < 8; t++) begin
            code = 3'($urandom_range(0, 7));
            fill(code);
            if ($urandom_range(0, 1) == 1) begin
                st = $urandom_range(1, 300);
                len = $urandom_range(1, 25);
                for (int n = st; n < st + len; n++)
                    hist[n] = code ^ 3'($urandom_range(1, 7));
            end
            run_case($sformatf("rnd%0d", t), 1'b0, de);
        end

        fill(3'b000);
        run_case("rr_first", 1'b0, de);
        repeat (20) step();
        chk("rr_hold_id", {16'h0, bus.lcd_id}, 32'h4342);
        chk("rr_hold_valid", {31'h0, bus.id_valid}, 1);
        for (int n = cyc + 1; n <= HMAX; n++) hist[n] = 3'b010;
        repeat (4) step();
        bus.reread = 1'b1;
        step();
        bus.reread = 1'b0;
        r = cyc;
        chk("rr_valid_fall", {31'h0, bus.id_valid}, 0);
        chk("rr_oe_fall", {31'h0, bus.lcd_rgb_oe}, 0);
        chk("rr_err_clr", {31'h0, bus.id_err}, 0);
        chk("rr_id_held", {16'h0, bus.lcd_id}, 32'h4342);
        repeat (3) step();
        bus.reread = 1'b1;
        step();
        bus.reread = 1'b0;
        wait_done(de);
        model(r + 1, me, res);
        check_done("rr_second", de, me, res);
        chk("rr_second_const", {16'h0, bus.lcd_id}, 32'h7016);

        fill(3'b100);
        run_case("rs_first", 1'b0, de);
        bus.reread = 1'b1;
        step();
        bus.reread = 1'b0;
        r = cyc;
        while (cyc < r + 1 + S + G + 3) step();
        rst_n = 1'b0;
        #1;
        chk("rs_oe", {31'h0, bus.lcd_rgb_oe}, 0);
        chk("rs_valid", {31'h0, bus.id_valid}, 0);
        chk("rs_id", {16'h0, bus.lcd_id}, 0);
        chk("rs_err", {31'h0, bus.id_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        wait_done(de);
        model(1, me, res);
        check_done("rs_again", de, me, res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
